alu_cmd_sequencer: RTL and testbench

- Sits directly upstream of the team's TinyALU and drives its start/op/A/B/reset_n interface.
- Buffers incoming commands in a small FIFO and issues them one at a time, holding start until done.
- Enforces a one-cycle drain gap between commands, completes no_op locally, and recovers from a hung ALU with a timeout plus a local ALU reset pulse.
- Returns each result on a valid/ready response channel.

---
 rtl/alu_cmd_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of the TinyALU.
// Queues commands, issues them one at a time, returns results.
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_err,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_reset_n,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP,
    RECOVER
  } state_t;

  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          in_rst;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  state_t        state;
  state_t        state_d;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_d;
  logic          rcnt;
  logic          rcnt_d;
  logic          alu_start_d;
  logic [2:0]    alu_op_d;
  logic [7:0]    alu_a_d;
  logic [7:0]    alu_b_d;
  logic          alu_reset_n_d;
  logic          rsp_valid_d;
  logic [15:0]   rsp_result_d;
  logic [2:0]    rsp_op_d;
  logic          rsp_err_d;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full && !in_rst;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];
  assign busy      = !empty || (state != IDLE);

  // Remember that reset was seen so cmd_ready stays low through it.
  always_ff @(posedge clk) begin
    in_rst <= reset;
  end

  // Command storage; contents need no reset, pointers gate validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // State and registered ALU/response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      rcnt        <= 1'b0;
      alu_start   <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_reset_n <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_op      <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      rcnt        <= rcnt_d;
      alu_start   <= alu_start_d;
      alu_op      <= alu_op_d;
      alu_a       <= alu_a_d;
      alu_b       <= alu_b_d;
      alu_reset_n <= alu_reset_n_d;
      rsp_valid   <= rsp_valid_d;
      rsp_result  <= rsp_result_d;
      rsp_op      <= rsp_op_d;
      rsp_err     <= rsp_err_d;
    end
  end

  // Next-state and next-output decode for the issue sequence.
  always_comb begin
    state_d       = state;
    timer_d       = timer;
    rcnt_d        = rcnt;
    alu_start_d   = alu_start;
    alu_op_d      = alu_op;
    alu_a_d       = alu_a;
    alu_b_d       = alu_b;
    alu_reset_n_d = 1'b1;
    rsp_valid_d   = rsp_valid;
    rsp_result_d  = rsp_result;
    rsp_op_d      = rsp_op;
    rsp_err_d     = rsp_err;
    pop           = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          rsp_op_d  = head.op;
          rsp_err_d = 1'b0;
          if (head.op == 3'b000) begin
            rsp_result_d = '0;
            state_d      = RESP;
          end else begin
            alu_op_d    = head.op;
            alu_a_d     = head.a;
            alu_b_d     = head.b;
            alu_start_d = 1'b1;
            timer_d     = '0;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (alu_done) begin
          rsp_result_d = alu_result;
          alu_start_d  = 1'b0;
          state_d      = DRAIN;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          alu_start_d   = 1'b0;
          rsp_err_d     = 1'b1;
          rsp_result_d  = '0;
          rcnt_d        = 1'b0;
          alu_reset_n_d = 1'b0;
          state_d       = RECOVER;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      DRAIN: begin
        if (!alu_done) state_d = RESP;
      end
      RECOVER: begin
        if (rcnt) begin
          state_d = RESP;
        end else begin
          rcnt_d        = 1'b1;
          alu_reset_n_d = 1'b0;
        end
      end
      RESP: begin
        if (!rsp_valid) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small TinyALU model.
// Single-cycle ops answer in the start cycle, mul on the 4th.
module tb_alu_cmd_sequencer;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_reset_n;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        busy;

  bit          hang;
  logic [2:0]  mcnt;

  int n_chk  = 0;
  int n_pass = 0;

  int run       = 0;
  int last_run  = 0;
  int starts    = 0;
  int rrun      = 0;
  int last_rrun = 0;

  alu_cmd_sequencer #(
    .FIFO_DEPTH(4),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_a(cmd_a),
    .cmd_b(cmd_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_result(rsp_result),
    .rsp_op(rsp_op),
    .rsp_err(rsp_err),
    .alu_start(alu_start),
    .alu_op(alu_op),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_reset_n(alu_reset_n),
    .alu_done(alu_done),
    .alu_result(alu_result),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: mul counts edges with start held.
  always @(posedge clk) begin
    if (!alu_reset_n || !alu_start) mcnt <= 3'd0;
    else if (mcnt != 3'd7) mcnt <= mcnt + 3'd1;
  end

  assign alu_done = !hang && alu_reset_n && alu_start &&
                    (alu_op[2] ? (mcnt == 3'd3) : (alu_op != 3'b000));

  always_comb begin
    alu_result = 16'h0000;
    if (alu_op[2]) begin
      alu_result = {8'h00, alu_a} * {8'h00, alu_b};
    end else begin
      case (alu_op[1:0])
        2'b01:   alu_result = {8'h00, alu_a} + {8'h00, alu_b};
        2'b10:   alu_result = {8'h00, alu_a & alu_b};
        2'b11:   alu_result = {8'h00, alu_a ^ alu_b};
        default: alu_result = 16'h0000;
      endcase
    end
  end

  // Pulse-length monitor for alu_start and alu_reset_n.
  always @(negedge clk) begin
    if (reset) begin
      run  = 0;
      rrun = 0;
    end else begin
      if (alu_start) begin
        run++;
      end else if (run != 0) begin
        last_run = run;
        starts++;
        run = 0;
      end
      if (!alu_reset_n) begin
        rrun++;
      end else if (rrun != 0) begin
        last_rrun = rrun;
        rrun = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 100) begin
      step();
      w++;
    end
    if (w >= 100) chk("send_ready_timeout", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    if (lat >= 100) chk("rsp_wait_timeout", {31'd0, rsp_valid}, 1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    int          lat;
    int          run;
  } vec_t;

  vec_t vecs[8];

  logic [15:0] exp_res[5];
  logic [2:0]  exp_op[5];

  initial begin
    int lat;
    int s0;
    int seen;

    vecs[0] = '{3'b001, 8'h12, 8'h34, 16'h0046, 4, 1};
    vecs[1] = '{3'b100, 8'hFF, 8'hFF, 16'hFE01, 7, 4};
    vecs[2] = '{3'b010, 8'hAA, 8'h0F, 16'h000A, 4, 1};
    vecs[3] = '{3'b011, 8'hF0, 8'h0F, 16'h00FF, 4, 1};
    vecs[4] = '{3'b000, 8'h55, 8'h66, 16'h0000, 2, 0};
    vecs[5] = '{3'b111, 8'h10, 8'h10, 16'h0100, 7, 4};
    vecs[6] = '{3'b001, 8'hFF, 8'h01, 16'h0100, 4, 1};
    vecs[7] = '{3'b110, 8'h00, 8'hFF, 16'h0000, 7, 4};

    exp_res = '{16'h00FF, 16'h0000, 16'h000A, 16'h000F, 16'h0100};
    exp_op  = '{3'b011, 3'b000, 3'b010, 3'b100, 3'b001};

    hang      = 1'b0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    rsp_ready = 1'b1;
    step();
    step();

    chk("rst_cmd_ready", {31'd0, cmd_ready}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_op, rsp_result}, 0);
    chk("rst_alu", {alu_start, alu_op, alu_a, alu_b}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_alu_reset_n", {31'd0, alu_reset_n}, 0);

    reset = 1'b0;
    step();
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("post_rst_alu_reset_n", {31'd0, alu_reset_n}, 1);

    for (int i = 0; i < 8; i++) begin
      s0 = starts;
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_rsp(lat);
      chk($sformatf("vec%0d_result", i), {16'd0, rsp_result}, {16'd0, vecs[i].res});
      chk($sformatf("vec%0d_op_err", i), {28'd0, rsp_op, rsp_err}, {28'd0, vecs[i].op, 1'b0});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      step();
      chk($sformatf("vec%0d_consumed", i), {31'd0, rsp_valid}, 0);
      chk($sformatf("vec%0d_starts", i), starts - s0, (vecs[i].run > 0) ? 1 : 0);
      if (vecs[i].run > 0) begin
        chk($sformatf("vec%0d_start_len", i), last_run, vecs[i].run);
        chk($sformatf("vec%0d_alu_ab", i), {16'd0, alu_a, alu_b},
            {16'd0, vecs[i].a, vecs[i].b});
      end
    end

    rsp_ready = 1'b0;
    send(3'b011, 8'hF0, 8'h0F);
    send(3'b000, 8'h00, 8'h00);
    send(3'b010, 8'hAA, 8'h0F);
    send(3'b100, 8'h03, 8'h05);
    send(3'b001, 8'hFF, 8'h01);
    chk("burst_full", {31'd0, cmd_ready}, 0);
    chk("burst_first_held", {15'd0, rsp_valid, rsp_result}, {15'd0, 1'b1, 16'h00FF});
    step();
    step();
    step();
    chk("burst_still_full", {31'd0, cmd_ready}, 0);
    chk("burst_still_held", {15'd0, rsp_valid, rsp_result}, {15'd0, 1'b1, 16'h00FF});
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(lat);
      chk($sformatf("burst%0d_result", k), {16'd0, rsp_result}, {16'd0, exp_res[k]});
      chk($sformatf("burst%0d_op", k), {29'd0, rsp_op}, {29'd0, exp_op[k]});
      step();
    end
    chk("burst_idle", {31'd0, busy}, 0);

    hang = 1'b1;
    send(3'b001, 8'h01, 8'h02);
    wait_rsp(lat);
    chk("to_err", {31'd0, rsp_err}, 1);
    chk("to_result", {16'd0, rsp_result}, 0);
    chk("to_start_len", last_run, 16);
    chk("to_reset_len", last_rrun, 2);
    chk("to_latency", lat, 20);
    step();
    hang = 1'b0;
    send(3'b001, 8'h20, 8'h22);
    wait_rsp(lat);
    chk("after_to_result", {15'd0, rsp_err, rsp_result}, {15'd0, 1'b0, 16'h0042});
    chk("after_to_latency", lat, 4);
    step();

    send(3'b100, 8'h02, 8'h03);
    step();
    cmd_valid = 1'b1;
    cmd_op    = 3'b001;
    cmd_a     = 8'h01;
    cmd_b     = 8'h01;
    step();
    cmd_valid = 1'b0;
    chk("mid_issue_start", {31'd0, alu_start}, 1);
    reset = 1'b1;
    step();
    chk("mid_rst_outputs", {28'd0, alu_start, rsp_valid, busy, cmd_ready}, 0);
    chk("mid_rst_alu_reset_n", {31'd0, alu_reset_n}, 0);
    reset = 1'b0;
    s0   = starts;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (rsp_valid || alu_start) seen++;
    end
    chk("mid_rst_no_activity", seen, 0);
    chk("mid_rst_no_start", starts - s0, 0);
    chk("mid_rst_ready", {30'd0, cmd_ready, busy}, {30'd0, 1'b1, 1'b0});

    rsp_ready = 1'b0;
    send(3'b001, 8'h12, 8'h01);
    send(3'b001, 8'h05, 8'h05);
    wait_rsp(lat);
    s0 = starts;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("bp_hold%0d", c), {11'd0, rsp_valid, alu_start, rsp_op, rsp_result},
          {11'd0, 1'b1, 1'b0, 3'b001, 16'h0013});
    end
    chk("bp_no_start", starts - s0, 0);
    rsp_ready = 1'b1;
    step();
    wait_rsp(lat);
    chk("bp_second_result", {16'd0, rsp_result}, 16'h000A);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
